// File: rtl/tx_pattern_pkg.sv
// Shared types and constants for the TX test-pattern generator and PRBS step logic.
package tx_pattern_pkg;

    localparam int W = 16;
    localparam logic [15:0] CLK_PAT = 16'hAAAA;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_CLK   = 2'd2,
        MODE_PRBS  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SEL_PRBS7     = 2'd0,
        SEL_PRBS15    = 2'd1,
        SEL_PRBS31    = 2'd2,
        SEL_PRBS31_B  = 2'd3
    } prbs_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Polynomial orders and second tap positions (1-based, as in x^N + x^T + 1)
    localparam int unsigned PRBS7_ORDER  = 7;
    localparam int unsigned PRBS7_TAP    = 6;
    localparam int unsigned PRBS15_ORDER = 15;
    localparam int unsigned PRBS15_TAP   = 14;
    localparam int unsigned PRBS31_ORDER = 31;
    localparam int unsigned PRBS31_TAP   = 28;

    function automatic logic [30:0] order_mask(input prbs_sel_t sel);
        case (sel)
            SEL_PRBS7:  return 31'h0000_007F;
            SEL_PRBS15: return 31'h0000_7FFF;
            default:    return 31'h7FFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/prbs_par_step.sv
// Combinational 16-step advance of a Fibonacci LFSR; word[15] is the first output bit.
module prbs_par_step
    import tx_pattern_pkg::*;
(
    input  logic [30:0]  lfsr,
    input  prbs_sel_t    prbs_sel,
    output logic [30:0]  lfsr_next,
    output logic [W-1:0] word
);

    logic [30:0] s;
    logic        msb;
    logic        fb;

    always_comb begin
        s    = lfsr;
        msb  = 1'b0;
        fb   = 1'b0;
        word = '0;
        for (int unsigned i = 0; i < W; i++) begin
            case (prbs_sel)
                SEL_PRBS7: begin
                    msb = s[PRBS7_ORDER-1];
                    fb  = s[PRBS7_ORDER-1] ^ s[PRBS7_TAP-1];
                end
                SEL_PRBS15: begin
                    msb = s[PRBS15_ORDER-1];
                    fb  = s[PRBS15_ORDER-1] ^ s[PRBS15_TAP-1];
                end
                default: begin
                    msb = s[PRBS31_ORDER-1];
                    fb  = s[PRBS31_ORDER-1] ^ s[PRBS31_TAP-1];
                end
            endcase
            word[W-1-i] = msb;
            s = {s[29:0], fb} & order_mask(prbs_sel);
        end
        lfsr_next = s;
    end

endmodule

// File: rtl/tx_pattern_gen.sv
// Parallel 16-bit test-pattern source for the TX serializer: zeros, fixed, clock and PRBS
// patterns with optional inversion and single-word error injection.
module tx_pattern_gen
    import tx_pattern_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       prbs_sel,
    input  logic [30:0]      seed,
    input  logic [W-1:0]     fixed_pat,
    input  logic             inv,
    input  logic             inj_err,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    output logic             seed_zero,
    output logic [CNT_W-1:0] inj_cnt
);

    state_t       state;
    mode_t        mode_q;
    prbs_sel_t    sel_q;
    logic         inv_q;
    logic [W-1:0] fixed_q;
    logic [30:0]  lfsr;
    logic         inj_d;

    logic [30:0]  lfsr_step;
    logic [W-1:0] prbs_word;
    logic [30:0]  seed_masked;
    logic [W-1:0] word;
    logic [W-1:0] err_mask;
    logic         inj_rise;

    prbs_par_step u_step (
        .lfsr      (lfsr),
        .prbs_sel  (sel_q),
        .lfsr_next (lfsr_step),
        .word      (prbs_word)
    );

    always_comb begin
        seed_masked = seed & order_mask(prbs_sel_t'(prbs_sel));
        case (mode_q)
            MODE_ZERO:  word = '0;
            MODE_FIXED: word = fixed_q;
            MODE_CLK:   word = CLK_PAT;
            default:    word = prbs_word;
        endcase
        inj_rise = inj_err & ~inj_d;
        err_mask = '0;
        if (state == ST_RUN && inj_rise)
            err_mask[W-1] = 1'b1;
    end

    // Settings and seed are captured on IDLE->LOAD; LOAD emits the first word on its way to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_ZERO;
            sel_q      <= SEL_PRBS7;
            inv_q      <= 1'b0;
            fixed_q    <= '0;
            lfsr       <= '0;
            inj_d      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            seed_zero  <= 1'b0;
            inj_cnt    <= '0;
        end else begin
            inj_d <= inj_err;
            case (state)
                ST_IDLE: begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                    if (en) begin
                        state   <= ST_LOAD;
                        mode_q  <= mode_t'(mode);
                        sel_q   <= prbs_sel_t'(prbs_sel);
                        inv_q   <= inv;
                        fixed_q <= fixed_pat;
                        if (seed_masked == '0) begin
                            lfsr      <= 31'd1;
                            seed_zero <= 1'b1;
                        end else begin
                            lfsr <= seed_masked;
                        end
                    end
                end
                ST_LOAD: begin
                    if (en) begin
                        state      <= ST_RUN;
                        dout       <= word ^ {W{inv_q}};
                        dout_valid <= 1'b1;
                        if (mode_q == MODE_PRBS)
                            lfsr <= lfsr_step;
                    end else begin
                        state      <= ST_IDLE;
                        dout       <= '0;
                        dout_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        dout       <= word ^ {W{inv_q}} ^ err_mask;
                        dout_valid <= 1'b1;
                        if (mode_q == MODE_PRBS)
                            lfsr <= lfsr_step;
                        if (inj_rise && inj_cnt != '1)
                            inj_cnt <= inj_cnt + 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        dout       <= '0;
                        dout_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
